// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement buffer. It allocates one entry per dispatched
//   instruction. The allocated index doubles as the rename tag. Results from
//   the common data bus are captured here, forwarded to operand lookups, and
//   retired one per cycle in program order.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           discard every in-flight entry
//   disp_*          allocation request/handshake and the allocated index
//   wb_*            common data bus result capture
//   rs1_*, rs2_*    operand lookup by rename tag, with same-cycle bypass
//   commit_*        head retirement to register file / alias table
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic                 disp_rd_wr,
  input  logic [4:0]           disp_rd_addr,
  output logic [ROB_PTR_W-1:0] disp_rob_id,
  input  logic                 wb_valid,
  input  logic [ROB_PTR_W-1:0] wb_rob_id,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [ROB_PTR_W-1:0] rs1_rob_id,
  input  logic [ROB_PTR_W-1:0] rs2_rob_id,
  output logic                 rs1_ready,
  output logic                 rs2_ready,
  output logic [DATA_W-1:0]    rs1_data,
  output logic [DATA_W-1:0]    rs2_data,
  output logic                 commit,
  output logic [ROB_PTR_W-1:0] commit_rob_id,
  output logic                 commit_rd_wr,
  output logic [4:0]           commit_rd_addr,
  output logic [DATA_W-1:0]    commit_data
);

  localparam logic [ROB_PTR_W:0] FULL_COUNT = (ROB_PTR_W + 1)'(ROB_DEPTH);

  logic [ROB_PTR_W-1:0] head_reg;
  logic [ROB_PTR_W-1:0] tail_reg;
  logic [ROB_PTR_W:0]   count_reg;

  // Per-entry state is owned by the generate blocks below and gathered here
  // for indexed reads.
  logic [ROB_DEPTH-1:0] valid_vec;
  logic [ROB_DEPTH-1:0] done_vec;
  logic [ROB_DEPTH-1:0] rd_wr_vec;
  logic [4:0]           rd_addr_arr [ROB_DEPTH];
  logic [DATA_W-1:0]    data_arr    [ROB_DEPTH];

  logic disp_fire;
  logic wb_hit;

  // Full blocks dispatch even when the head retires this cycle: the check
  // uses the registered count only.
  assign disp_ready  = (count_reg != FULL_COUNT);
  assign disp_fire   = disp_valid & disp_ready;
  assign disp_rob_id = tail_reg;

  // Writebacks to entries that are not allocated are dropped.
  assign wb_hit = wb_valid & valid_vec[wb_rob_id];

  // Retirement looks only at registered state, so a writeback to the head
  // retires on the following cycle at the earliest.
  assign commit         = valid_vec[head_reg] & done_vec[head_reg] & ~flush & ~rst;
  assign commit_rob_id  = head_reg;
  assign commit_rd_wr   = rd_wr_vec[head_reg];
  assign commit_rd_addr = rd_addr_arr[head_reg];
  assign commit_data    = data_arr[head_reg];

  // Operand lookup for both source ports.
  logic [ROB_PTR_W-1:0] rs_tag   [2];
  logic                 rs_rdy   [2];
  logic [DATA_W-1:0]    rs_value [2];

  assign rs_tag[0] = rs1_rob_id;
  assign rs_tag[1] = rs2_rob_id;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rs
      logic bypass;
      assign bypass       = wb_valid & (wb_rob_id == rs_tag[gi]) & valid_vec[rs_tag[gi]];
      assign rs_rdy[gi]   = done_vec[rs_tag[gi]] | bypass;
      assign rs_value[gi] = bypass ? wb_data : data_arr[rs_tag[gi]];
    end
  endgenerate

  assign rs1_ready = rs_rdy[0];
  assign rs2_ready = rs_rdy[1];
  assign rs1_data  = rs_value[0];
  assign rs2_data  = rs_value[1];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (disp_fire) tail_reg <= tail_reg + ROB_PTR_W'(1);
      if (commit)    head_reg <= head_reg + ROB_PTR_W'(1);
      case ({disp_fire, commit})
        2'b10:   count_reg <= count_reg + (ROB_PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (ROB_PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  generate
    for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      localparam logic [ROB_PTR_W-1:0] IDX = ROB_PTR_W'(gi);

      logic valid_reg;
      logic done_reg;
      logic rd_wr_reg;
      logic [4:0] rd_addr_reg;
      logic [DATA_W-1:0] data_reg;

      logic alloc_here;
      logic retire_here;
      logic wb_here;

      // Allocation targets an invalid entry and a writeback needs a valid one,
      // so the two can never land on the same entry in one cycle.
      assign alloc_here  = disp_fire & (tail_reg == IDX);
      assign retire_here = commit & (head_reg == IDX);
      assign wb_here     = wb_hit & (wb_rob_id == IDX);

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else begin
          if (alloc_here)       valid_reg <= 1'b1;
          else if (retire_here) valid_reg <= 1'b0;
          if (alloc_here)       done_reg  <= 1'b0;
          else if (wb_here)     done_reg  <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_wr_reg <= 1'b0;
        end else if (alloc_here && !flush) begin
          rd_wr_reg   <= disp_rd_wr;
          rd_addr_reg <= disp_rd_addr;
        end
      end

      always_ff @(posedge clk) begin
        if (wb_here && !flush && !rst) data_reg <= wb_data;
      end

      assign valid_vec[gi]   = valid_reg;
      assign done_vec[gi]    = done_reg;
      assign rd_wr_vec[gi]   = rd_wr_reg;
      assign rd_addr_arr[gi] = rd_addr_reg;
      assign data_arr[gi]    = data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Directed scenarios with literal expectations, then randomized traffic.
//   A program-order queue model predicts every output and is compared on
//   each falling clock edge.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          disp_valid, disp_ready, disp_rd_wr;
  logic [4:0]    disp_rd_addr;
  logic [PW-1:0] disp_rob_id;
  logic          wb_valid;
  logic [PW-1:0] wb_rob_id;
  logic [DW-1:0] wb_data;
  logic [PW-1:0] rs1_rob_id, rs2_rob_id;
  logic          rs1_ready, rs2_ready;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          commit;
  logic [PW-1:0] commit_rob_id;
  logic          commit_rd_wr;
  logic [4:0]    commit_rd_addr;
  logic [DW-1:0] commit_data;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .ROB_PTR_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd_wr(disp_rd_wr),
    .disp_rd_addr(disp_rd_addr), .disp_rob_id(disp_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
    .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .commit(commit), .commit_rob_id(commit_rob_id), .commit_rd_wr(commit_rd_wr),
    .commit_rd_addr(commit_rd_addr), .commit_data(commit_data)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Model: per-index bookkeeping plus a queue of in-flight ids in program order.
  bit          m_valid [DEPTH];
  bit          m_done  [DEPTH];
  bit          m_rdwr  [DEPTH];
  logic [4:0]  m_rd    [DEPTH];
  logic [31:0] m_data  [DEPTH];
  int          q[$];
  int          m_tail;

  function automatic int m_head();
    return (m_tail - q.size() + DEPTH) % DEPTH;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    bit exp_commit;
    int tag;
    bit byp, rdy;
    logic [31:0] ed;
    exp_commit = !flush && q.size() > 0 && m_done[q[0]];
    chk("disp_ready", 32'(disp_ready), 32'(q.size() != DEPTH));
    chk("disp_rob_id", 32'(disp_rob_id), 32'(m_tail));
    chk("commit", 32'(commit), 32'(exp_commit));
    chk("commit_rob_id", 32'(commit_rob_id), 32'(m_head()));
    if (exp_commit) begin
      chk("commit_rd_wr", 32'(commit_rd_wr), 32'(m_rdwr[q[0]]));
      chk("commit_rd_addr", 32'(commit_rd_addr), 32'(m_rd[q[0]]));
      chk("commit_data", commit_data, m_data[q[0]]);
    end
    for (int p = 0; p < 2; p++) begin
      tag = (p == 0) ? int'(rs1_rob_id) : int'(rs2_rob_id);
      byp = wb_valid && (int'(wb_rob_id) == tag) && m_valid[tag];
      rdy = m_done[tag] || byp;
      ed  = byp ? wb_data : m_data[tag];
      chk($sformatf("rs%0d_ready", p + 1), 32'((p == 0) ? rs1_ready : rs2_ready), 32'(rdy));
      if (rdy) chk($sformatf("rs%0d_data", p + 1), (p == 0) ? rs1_data : rs2_data, ed);
    end
  endtask

  always @(negedge clk) if (check_en) check_all();

  task automatic model_update();
    bit c, f;
    int id;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_done[i]  = 1'b0;
      end
      q.delete();
      m_tail = 0;
      if (flush && !rst) $display("flush");
    end else begin
      c = q.size() > 0 && m_done[q[0]];
      f = disp_valid && q.size() < DEPTH;
      if (wb_valid && m_valid[wb_rob_id]) begin
        m_done[wb_rob_id] = 1'b1;
        m_data[wb_rob_id] = wb_data;
      end
      if (c) begin
        id = q.pop_front();
        m_valid[id] = 1'b0;
        $display("commit id=%0d rd_wr=%0d rd=%0d data=%08h", id, m_rdwr[id], m_rd[id], m_data[id]);
      end
      if (f) begin
        m_valid[m_tail] = 1'b1;
        m_done[m_tail]  = 1'b0;
        m_rdwr[m_tail]  = disp_rd_wr;
        m_rd[m_tail]    = disp_rd_addr;
        q.push_back(m_tail);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_valid   = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic disp(input bit wr, input int rd);
    disp_valid   = 1'b1;
    disp_rd_wr   = wr;
    disp_rd_addr = 5'(rd);
  endtask

  task automatic wb(input int id, input logic [31:0] d);
    wb_valid  = 1'b1;
    wb_rob_id = PW'(id);
    wb_data   = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_rd_wr = 1'b0; disp_rd_addr = '0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_data = '0; rs1_rob_id = '0; rs2_rob_id = '0;
    do_reset();

    // Reset values.
    #2;
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_disp_rob_id", 32'(disp_rob_id), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_commit_rd_wr", 32'(commit_rd_wr), 32'd0);
    chk("rst_commit_rob_id", 32'(commit_rob_id), 32'd0);
    chk("rst_rs1_ready", 32'(rs1_ready), 32'd0);
    chk("rst_rs2_ready", 32'(rs2_ready), 32'd0);

    // Fill with 16 back-to-back dispatches.
    for (int i = 0; i < DEPTH; i++) begin
      disp(1'b1, i + 1);
      #2;
      chk("fill_id", 32'(disp_rob_id), 32'(i));
      tick();
    end
    #2;
    chk("full_ready", 32'(disp_ready), 32'd0);
    chk("full_commit", 32'(commit), 32'd0);

    // Full with a simultaneous commit: dispatch still blocked.
    wb(0, 32'hAA);
    tick();
    wb_valid = 1'b0;
    #2;
    chk("fullc_commit", 32'(commit), 32'd1);
    chk("fullc_ready", 32'(disp_ready), 32'd0);
    tick();
    #2;
    chk("wrap_ready", 32'(disp_ready), 32'd1);
    chk("wrap_id", 32'(disp_rob_id), 32'd0);
    tick();
    idle();

    // In-order retirement.
    do_reset();
    disp(1'b1, 5); tick();
    disp(1'b1, 6); tick();
    disp(1'b1, 7); tick();
    idle();
    wb(2, 32'h33); tick();
    wb(0, 32'h11);
    #2;
    chk("ooo_no_commit", 32'(commit), 32'd0);
    tick();
    wb(1, 32'h22);
    #2;
    chk("ret0_commit", 32'(commit), 32'd1);
    chk("ret0_id", 32'(commit_rob_id), 32'd0);
    chk("ret0_rd", 32'(commit_rd_addr), 32'd5);
    chk("ret0_data", commit_data, 32'h11);
    tick();
    wb_valid = 1'b0;
    #2;
    chk("ret1_commit", 32'(commit), 32'd1);
    chk("ret1_id", 32'(commit_rob_id), 32'd1);
    chk("ret1_rd", 32'(commit_rd_addr), 32'd6);
    chk("ret1_data", commit_data, 32'h22);
    tick();
    #2;
    chk("ret2_commit", 32'(commit), 32'd1);
    chk("ret2_id", 32'(commit_rob_id), 32'd2);
    chk("ret2_rd", 32'(commit_rd_addr), 32'd7);
    chk("ret2_data", commit_data, 32'h33);
    tick();
    #2;
    chk("ret_empty", 32'(commit), 32'd0);

    // Operand forwarding, then flush mid-operation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      disp(1'b1, i + 1);
      tick();
    end
    idle();
    rs1_rob_id = 4'd3;
    wb(3, 32'hDEAD);
    #2;
    chk("fwd_bypass_ready", 32'(rs1_ready), 32'd1);
    chk("fwd_bypass_data", rs1_data, 32'hDEAD);
    tick();
    wb(1, 32'hBEEF);
    #2;
    chk("fwd_stored_ready", 32'(rs1_ready), 32'd1);
    chk("fwd_stored_data", rs1_data, 32'hDEAD);
    tick();
    flush = 1'b1;
    disp(1'b1, 9);
    wb(0, 32'h55);
    #2;
    chk("flush_commit", 32'(commit), 32'd0);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    wb(1, 32'h99);
    rs1_rob_id = 4'd1;
    #2;
    chk("postflush_ready", 32'(disp_ready), 32'd1);
    chk("postflush_commit", 32'(commit), 32'd0);
    chk("postflush_id", 32'(disp_rob_id), 32'd0);
    chk("stale_wb_bypass", 32'(rs1_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #2;
    chk("stale_wb_ignored", 32'(rs1_ready), 32'd0);
    chk("stale_no_commit", 32'(commit), 32'd0);

    // Stray writeback and a store retirement.
    disp(1'b0, 9);
    tick();
    idle();
    wb(7, 32'h77);
    rs2_rob_id = 4'd7;
    #2;
    chk("stray_bypass", 32'(rs2_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #2;
    chk("stray_ignored", 32'(rs2_ready), 32'd0);
    chk("stray_no_commit", 32'(commit), 32'd0);
    chk("stray_tail", 32'(disp_rob_id), 32'd1);
    wb(0, 32'h5A);
    tick();
    wb_valid = 1'b0;
    #2;
    chk("store_commit", 32'(commit), 32'd1);
    chk("store_rd_wr", 32'(commit_rd_wr), 32'd0);
    chk("store_rd", 32'(commit_rd_addr), 32'd9);
    chk("store_data", commit_data, 32'h5A);
    tick();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      disp_valid   = ($urandom_range(99) < 60);
      disp_rd_wr   = ($urandom_range(3) != 0);
      disp_rd_addr = 5'($urandom);
      wb_valid     = $urandom_range(1) == 1;
      if (q.size() > 0 && $urandom_range(3) != 0)
        wb_rob_id = PW'(q[$urandom_range(q.size() - 1)]);
      else
        wb_rob_id = PW'($urandom);
      wb_data = $urandom;
      flush   = ($urandom_range(99) == 0);
      if (q.size() > 0 && $urandom_range(1) == 1)
        rs1_rob_id = PW'(q[$urandom_range(q.size() - 1)]);
      else
        rs1_rob_id = PW'($urandom);
      rs2_rob_id = PW'($urandom);
      tick();
    end
    idle();
    tick();
    tick();
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
